// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake between a producer and the UART transmitter FIFO.
interface uart_tx_fifo_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; baud set per frame from MODE.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned DIV_4800   = 2604,
  parameter int unsigned DIV_9600   = 1302,
  parameter int unsigned DIV_14K4   = 868,
  parameter int unsigned DIV_19K2   = 651
) (
  input  logic                          SCLK,
  input  logic                          SCLR,
  input  logic [1:0]                    MODE,
  uart_tx_fifo_if.slave                 tx_if,
  output logic                          TX,
  output logic                          TX_BUSY,
  output logic                          TX_DONE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned MAX_A   = (DIV_4800 > DIV_9600) ? DIV_4800 : DIV_9600;
  localparam int unsigned MAX_B   = (DIV_14K4 > DIV_19K2) ? DIV_14K4 : DIV_19K2;
  localparam int unsigned MAX_DIV = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(OVERSAMPLE * MAX_DIV + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_shift;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_bit_clks;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0] w_bit_clks;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic          w_pre_last;

  always_comb begin
    w_bit_clks = CW'(OVERSAMPLE * DIV_4800);
    unique case (MODE)
      2'b00: w_bit_clks = CW'(OVERSAMPLE * DIV_4800);
      2'b01: w_bit_clks = CW'(OVERSAMPLE * DIV_9600);
      2'b10: w_bit_clks = CW'(OVERSAMPLE * DIV_14K4);
      2'b11: w_bit_clks = CW'(OVERSAMPLE * DIV_19K2);
    endcase
  end

  assign w_full         = (r_count == (AW+1)'(FIFO_DEPTH));
  assign tx_if.TX_READY = !w_full;
  assign w_push         = tx_if.TX_VALID && !w_full;
  assign w_last         = (r_cnt == r_bit_clks - CW'(1));
  assign w_pre_last     = (r_cnt == r_bit_clks - CW'(2));
  // Pops only from a registered non-zero count: a byte written this edge waits one cycle.
  assign w_pop          = (r_count != '0) &&
                          ((r_state == IDLE) || ((r_state == STOP) && w_last));

  always_ff @(posedge SCLK) begin
    if (w_push) r_mem[r_wptr] <= tx_if.TX_DATA;
  end

  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_bit_clks <= '0;
    end else begin
      // Registered so the pulse lands on the final cycle of the stop bit.
      r_done <= (r_state == STOP) && w_pre_last;
      r_cnt  <= r_cnt + CW'(1);
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_shift    <= r_mem[r_rptr];
            r_bit_clks <= w_bit_clks;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_idx   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift    <= r_mem[r_rptr];
              r_bit_clks <= w_bit_clks;
              r_tx       <= 1'b0;
              r_state    <= START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign TX         = r_tx;
  assign TX_BUSY    = r_busy;
  assign TX_DONE    = r_done;
  assign FIFO_COUNT = r_count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: writes push expected frames, a line monitor decodes TX and pops them.
module tb_uart_tx_fifo;
  localparam int unsigned OS  = 4;
  localparam int unsigned D00 = 16;
  localparam int unsigned D01 = 8;
  localparam int unsigned D10 = 6;
  localparam int unsigned D11 = 4;
  localparam int unsigned B00 = OS * D00;
  localparam int unsigned B01 = OS * D01;
  localparam int unsigned B10 = OS * D10;
  localparam int unsigned B11 = OS * D11;

  typedef struct {
    logic [7:0]  data;
    int unsigned bclk;
  } exp_t;

  logic        SCLK = 1'b0;
  logic        SCLR = 1'b1;
  logic [1:0]  MODE = 2'b11;
  logic        TX, TX_BUSY, TX_DONE;
  logic [2:0]  FIFO_COUNT;

  uart_tx_fifo_if u_if ();

  uart_tx_fifo #(
    .FIFO_DEPTH (4),
    .OVERSAMPLE (OS),
    .DIV_4800   (D00),
    .DIV_9600   (D01),
    .DIV_14K4   (D10),
    .DIV_19K2   (D11)
  ) dut (
    .SCLK       (SCLK),
    .SCLR       (SCLR),
    .MODE       (MODE),
    .tx_if      (u_if.slave),
    .TX         (TX),
    .TX_BUSY    (TX_BUSY),
    .TX_DONE    (TX_DONE),
    .FIFO_COUNT (FIFO_COUNT)
  );

  always #5 SCLK = ~SCLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned frames_done = 0;
  int unsigned wcyc     = 0;
  logic        mon_en   = 1'b1;
  exp_t        exp_q [$];
  int unsigned starts [$];

  always @(posedge SCLK) cyc <= cyc + 1;
  always @(negedge SCLK) if (TX_DONE === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic exp_rdy, input int unsigned bclk);
    @(negedge SCLK);
    u_if.TX_VALID = 1'b1;
    u_if.TX_DATA  = d;
    wcyc = cyc + 1;
    check("tx_ready", 32'(u_if.TX_READY), 32'(exp_rdy));
    if (exp_rdy && mon_en) exp_q.push_back('{data: d, bclk: bclk});
    @(posedge SCLK);
  endtask

  task automatic idle_valid();
    @(negedge SCLK);
    u_if.TX_VALID = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int unsigned target, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge SCLK);
      if (frames_done >= target) break;
    end
    check(tag, frames_done, target);
  endtask

  // Line monitor: decodes each frame and checks every sample against the expected level.
  initial begin
    exp_t        e;
    logic [9:0]  frame;
    logic [9:0]  rx;
    int unsigned bad;
    int unsigned donebad;
    forever begin
      @(negedge SCLK);
      if (mon_en && TX === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          frame = {1'b1, e.data, 1'b0};
          rx = '0;
          bad = 0;
          donebad = 0;
          for (int unsigned i = 0; i < 10; i++) begin
            for (int unsigned c = 0; c < e.bclk; c++) begin
              if (!(i == 0 && c == 0)) @(negedge SCLK);
              if (TX !== frame[i]) bad++;
              if (c == e.bclk / 2) rx[i] = TX;
              if (TX_DONE !== ((i == 9) && (c == e.bclk - 1))) donebad++;
            end
          end
          check("frame_wave", bad, 0);
          check("rx_data", 32'(rx[8:1]), 32'(e.data));
          check("rx_err", 32'((rx[0] !== 1'b0) || (rx[9] !== 1'b1)), 0);
          check("done_timing", donebad, 0);
          frames_done++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned d0;
    int unsigned lows;
    logic [7:0]  rb;
    u_if.TX_VALID = 1'b0;
    u_if.TX_DATA  = '0;

    // Reset
    repeat (2) @(posedge SCLK);
    @(negedge SCLK);
    check("rst_tx", 32'(TX), 1);
    check("rst_ready", 32'(u_if.TX_READY), 1);
    check("rst_busy", 32'(TX_BUSY), 0);
    check("rst_done", 32'(TX_DONE), 0);
    check("rst_count", 32'(FIFO_COUNT), 0);
    SCLR = 1'b0;

    // Single 0x55 frame at MODE=11
    d0 = done_cnt;
    MODE = 2'b11;
    send(8'h55, 1'b1, B11);
    idle_valid();
    wait_frames("frames_t2", 1, 12 * B11);
    @(negedge SCLK);
    check("latency", starts[0] - wcyc, 1);
    check("done_once", done_cnt - d0, 1);
    check("busy_drop", 32'(TX_BUSY), 0);
    check("idle_tx", 32'(TX), 1);

    // Burst of 6 into a depth-4 FIFO
    base = starts.size();
    d0 = done_cnt;
    for (int unsigned i = 0; i < 6; i++) send(8'(i + 1), i < 5, B11);
    @(negedge SCLK);
    u_if.TX_VALID = 1'b0;
    check("full_count", 32'(FIFO_COUNT), 4);
    wait_frames("frames_t3", 6, 60 * B11);
    @(negedge SCLK);
    check("done_five", done_cnt - d0, 5);
    check("drain_count", 32'(FIFO_COUNT), 0);
    if (starts.size() >= base + 5)
      for (int unsigned j = 1; j < 5; j++)
        check("b2b_gap", starts[base + j] - starts[base + j - 1], 10 * B11);

    // MODE switch mid-frame affects only the next frame
    base = starts.size();
    MODE = 2'b11;
    send(8'hA3, 1'b1, B11);
    idle_valid();
    repeat (3 * B11) @(posedge SCLK);
    @(negedge SCLK);
    MODE = 2'b00;
    send(8'h3C, 1'b1, B00);
    idle_valid();
    wait_frames("frames_t4", 8, 10 * B11 + 10 * B00 + 50);
    if (starts.size() >= base + 2)
      check("mode_latch_len", starts[base + 1] - starts[base], 10 * B11);

    // Reset during data bit 3 with bytes queued
    repeat (4) @(posedge SCLK);
    mon_en = 1'b0;
    MODE = 2'b11;
    send(8'h11, 1'b1, B11);
    send(8'h22, 1'b1, B11);
    send(8'h33, 1'b1, B11);
    idle_valid();
    repeat (4 * B11 + 4) @(posedge SCLK);
    @(negedge SCLK);
    check("pre_rst_tx", 32'(TX), 0);
    check("pre_rst_count", 32'(FIFO_COUNT), 2);
    d0 = done_cnt;
    SCLR = 1'b1;
    @(posedge SCLK);
    #1;
    check("abort_tx", 32'(TX), 1);
    check("abort_count", 32'(FIFO_COUNT), 0);
    check("abort_busy", 32'(TX_BUSY), 0);
    @(negedge SCLK);
    SCLR = 1'b0;
    lows = 0;
    for (int unsigned i = 0; i < 12 * B11; i++) begin
      @(negedge SCLK);
      if (TX !== 1'b1) lows++;
    end
    check("no_frame_after_rst", lows, 0);
    check("no_done_after_rst", done_cnt - d0, 0);
    mon_en = 1'b1;

    // Boundary bytes and a random byte at MODE=01, one byte at MODE=10
    MODE = 2'b01;
    rb = 8'($urandom_range(255));
    send(8'h00, 1'b1, B01);
    send(8'hFF, 1'b1, B01);
    send(rb, 1'b1, B01);
    idle_valid();
    wait_frames("frames_t6", 11, 30 * B01 + 50);
    MODE = 2'b10;
    send(8'h80, 1'b1, B10);
    idle_valid();
    wait_frames("frames_t7", 12, 10 * B10 + 50);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
